rtc_read_sequencer: RTL and testbench

// - Bus master for the RTC multiplexed address/data bus; upstream of the display register bank.
// - On request, runs one read cycle per RTC register for 11 registers: clock 0x21-0x28, timer 0x41-0x43.
// - Drives address, data_vga, Read, Write and AoD exactly as the register bank samples them.
// - Also exposes the raw bus pins: cs_n, rd_n, wr_n, ad_out/ad_oe, ad_in.

---
 rtl/rtc_bus_pkg.sv | 31 +++
 rtl/rtc_phase_timer.sv | 30 +++
 rtl/rtc_read_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus read sequencer.
//   NUM_RTC_REGS  number of RTC registers mirrored by the display bank
//   ADDR_TABLE    RTC register addresses in scan order (clock block, then timer block)
//   rtc_state_t   sequencer FSM states
//   rtc_reg_addr  table lookup that returns 0 for an out-of-range index
package rtc_bus_pkg;

   localparam int NUM_RTC_REGS = 11;

   localparam logic [7:0] ADDR_TABLE [0:NUM_RTC_REGS-1] = '{
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
      8'h41, 8'h42, 8'h43
   };

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      AHOLD   = 3'd2,
      DATA    = 3'd3,
      RELEASE = 3'd4,
      DONE    = 3'd5
   } rtc_state_t;

   function automatic logic [7:0] rtc_reg_addr(input logic [3:0] idx);
      logic [7:0] a;
      a = 8'h00;
      if (idx < 4'(NUM_RTC_REGS)) a = ADDR_TABLE[idx];
      return a;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: a down-counter reloaded with PHASE_CYC-1 on load, so the
// terminal count (phase_last) is reached in the PHASE_CYC-th cycle of a phase.
//   clk         system clock
//   reset       synchronous, active-low reset
//   load        reload the counter (asserted on every FSM state change)
//   phase_last  1 in the final cycle of the current phase
module rtc_phase_timer #(
   parameter int PHASE_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic phase_last
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= 4'(PHASE_CYC - 1);
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign phase_last = (cnt == 4'd0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: bus master on the RTC multiplexed address/data bus that
// reads each register of ADDR_TABLE in turn and hands address/data to the
// display register bank.
//   clk, reset            system clock, synchronous active-low reset
//   start, continuous     scan request pulse / free-running scan level
//   ad_in                 bus read-back from the pad
//   ad_out, ad_oe         bus drive value and pad output enable
//   cs_n, AoD             chip select (low active), 0=address / 1=data phase
//   Write, Read           RTC wr_n / rd_n (low active)
//   address, data_vga     register address and captured data for the bank
//   reg_index             index of the register being read
//   busy, done            scan in progress / one-cycle end-of-scan pulse
//
// State table:
//   IDLE    | bus released, waiting for start or continuous
//   ADDR    | cs_n low, address driven, Write low
//   AHOLD   | Write high, address still driven
//   DATA    | bus turned around, Read low, data captured every cycle
//   RELEASE | Read and cs_n high, address/data held for the bank
//   DONE    | one-cycle done pulse, then back to IDLE
module rtc_read_sequencer
   import rtc_bus_pkg::*;
#(
   parameter int PHASE_CYC = 4,
   parameter int NUM_REGS  = NUM_RTC_REGS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       continuous,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       AoD,
   output logic       Write,
   output logic       Read,
   output logic [7:0] address,
   output logic [7:0] data_vga,
   output logic [3:0] reg_index,
   output logic       busy,
   output logic       done
);

   rtc_state_t state, state_nxt;
   logic [3:0] idx_nxt;
   logic       phase_last;
   logic       load;

   logic [7:0] ad_out_nxt, address_nxt;
   logic       ad_oe_nxt, cs_n_nxt, aod_nxt, write_nxt, read_nxt, busy_nxt, done_nxt;

   rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_phase_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .phase_last (phase_last)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = reg_index;
      case (state)
         IDLE: begin
            if (start || continuous) begin
               state_nxt = ADDR;
               idx_nxt   = 4'd0;
            end
         end
         ADDR:    if (phase_last) state_nxt = AHOLD;
         AHOLD:   if (phase_last) state_nxt = DATA;
         DATA:    if (phase_last) state_nxt = RELEASE;
         RELEASE: begin
            if (phase_last) begin
               if (reg_index == 4'(NUM_REGS - 1)) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt   = reg_index + 4'd1;
                  state_nxt = ADDR;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every state is a new phase, so the timer restarts on any transition.
   assign load = (state_nxt != state);

   // Outputs are decoded from the next state and registered, so they switch
   // on the same edge as the state and only at phase boundaries.
   always_comb begin
      cs_n_nxt    = 1'b1;
      aod_nxt     = 1'b0;
      write_nxt   = 1'b1;
      read_nxt    = 1'b1;
      ad_oe_nxt   = 1'b0;
      ad_out_nxt  = ad_out;
      address_nxt = address;
      busy_nxt    = 1'b1;
      done_nxt    = 1'b0;
      case (state_nxt)
         IDLE: busy_nxt = 1'b0;
         ADDR: begin
            cs_n_nxt    = 1'b0;
            write_nxt   = 1'b0;
            ad_oe_nxt   = 1'b1;
            ad_out_nxt  = rtc_reg_addr(idx_nxt);
            address_nxt = rtc_reg_addr(idx_nxt);
         end
         AHOLD: begin
            cs_n_nxt  = 1'b0;
            ad_oe_nxt = 1'b1;
         end
         DATA: begin
            cs_n_nxt = 1'b0;
            aod_nxt  = 1'b1;
            read_nxt = 1'b0;
         end
         RELEASE: ;
         DONE: begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
         end
         default: busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         reg_index <= 4'd0;
         cs_n      <= 1'b1;
         AoD       <= 1'b0;
         Write     <= 1'b1;
         Read      <= 1'b1;
         ad_oe     <= 1'b0;
         ad_out    <= 8'h00;
         address   <= 8'h00;
         data_vga  <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         reg_index <= idx_nxt;
         cs_n      <= cs_n_nxt;
         AoD       <= aod_nxt;
         Write     <= write_nxt;
         Read      <= read_nxt;
         ad_oe     <= ad_oe_nxt;
         ad_out    <= ad_out_nxt;
         address   <= address_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         // Sampled while Read is low; the bank therefore sees each sample one cycle late.
         if (state == DATA) data_vga <= ad_in;
      end
   end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
module tb_rtc_read_sequencer;

   localparam logic [7:0] TB_TABLE [0:10] = '{
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43
   };

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [3:0] idx;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // P=4 instance
   logic       start4, cont4;
   logic [7:0] ad_in4, ad_out4, addr4, dv4;
   logic       ad_oe4, cs_n4, aod4, wr4, rd4, busy4, done4;
   logic [3:0] idx4;
   // P=2 instance with a register bank attached
   logic       start2, cont2;
   logic [7:0] ad_in2, ad_out2, addr2, dv2;
   logic       ad_oe2, cs_n2, aod2, wr2, rd2, busy2, done2;
   logic [3:0] idx2;

   logic [7:0] mem   [0:255];
   logic [7:0] bank2 [0:255];
   logic [7:0] rtc_a4, rtc_a2, junk;
   exp_t       sb_q[$];
   int         dones = 0;
   int         busy_falls = 0;

   rtc_read_sequencer #(.PHASE_CYC(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .continuous(cont4), .ad_in(ad_in4),
      .ad_out(ad_out4), .ad_oe(ad_oe4), .cs_n(cs_n4), .AoD(aod4), .Write(wr4), .Read(rd4),
      .address(addr4), .data_vga(dv4), .reg_index(idx4), .busy(busy4), .done(done4)
   );

   rtc_read_sequencer #(.PHASE_CYC(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .continuous(cont2), .ad_in(ad_in2),
      .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2), .AoD(aod2), .Write(wr2), .Read(rd2),
      .address(addr2), .data_vga(dv2), .reg_index(idx2), .busy(busy2), .done(done2)
   );

   // RTC model: returns its register contents while selected and read, junk otherwise.
   assign ad_in4 = (!cs_n4 && !rd4) ? mem[rtc_a4] : junk;
   assign ad_in2 = (!cs_n2 && !rd2) ? mem[rtc_a2] : junk;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RTC address latch, junk source and the P=2 register bank.
   initial forever begin
      @(negedge clk);
      junk = 8'($urandom);
      if (!cs_n4 && ad_oe4 && !aod4) rtc_a4 = ad_out4;
      if (!cs_n2 && ad_oe2 && !aod2) rtc_a2 = ad_out2;
      if (reset && !rd2 && aod2) bank2[addr2] = dv2;
      if (reset && !wr2 && !rd2) check("p2_rd_wr_overlap", 1, 0);
   end

   // Monitor for the P=4 instance: protocol rules and scoreboard.
   int   prev_cls = 0;
   int   run_len = 0;
   logic prev_rd = 1'b1;
   logic prev_busy = 1'b0;
   logic [7:0] prev_addr = 8'h00;
   initial forever begin
      int   cls;
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         prev_cls = 0;
         run_len  = 0;
      end else begin
         check("rd_wr_overlap", {31'd0, (!wr4 && !rd4)}, 0);
         check("oe_in_data", {31'd0, (aod4 && ad_oe4)}, 0);
         if (aod4 || !wr4 || ad_oe4) check("cs_n_active", {31'd0, cs_n4}, 0);
         cls = !busy4 ? 0 : (aod4 ? 3 : (cs_n4 ? 4 : (!wr4 ? 1 : 2)));
         if (cls != prev_cls) begin
            if (prev_cls != 0) check($sformatf("phase_width_%0d", prev_cls), run_len, 4);
            run_len = 1;
         end else begin
            run_len++;
            if (cls != 0) check("addr_stable_in_phase", addr4, prev_addr);
         end
         prev_cls = cls;
         if (!prev_rd && rd4) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_read", {24'd0, addr4}, 0);
            end else begin
               e = sb_q.pop_front();
               check("sb_addr", addr4, e.addr);
               check("sb_data", dv4, e.data);
               check("sb_idx", idx4, e.idx);
            end
         end
         if (done4) dones++;
         if (prev_busy && !busy4) busy_falls++;
      end
      prev_rd   = rd4;
      prev_busy = busy4;
      prev_addr = addr4;
   end

   task automatic push_scan();
      for (int i = 0; i < 11; i++) sb_q.push_back('{TB_TABLE[i], mem[TB_TABLE[i]], 4'(i)});
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 11; i++) mem[TB_TABLE[i]] = 8'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cs_n"}, cs_n4, 1);
      check({tag, "_read"}, rd4, 1);
      check({tag, "_write"}, wr4, 1);
      check({tag, "_aod"}, aod4, 0);
      check({tag, "_ad_oe"}, ad_oe4, 0);
      check({tag, "_ad_out"}, ad_out4, 0);
      check({tag, "_address"}, addr4, 0);
      check({tag, "_data_vga"}, dv4, 0);
      check({tag, "_reg_index"}, idx4, 0);
      check({tag, "_busy"}, busy4, 0);
      check({tag, "_done"}, done4, 0);
   endtask

   task automatic wait_done4(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done4 && n < budget);
      if (!done4) check({tag, "_done_timeout"}, 0, 1);
   endtask

   // One start-triggered scan; extra start pulses in cycles ign_a/ign_b (start cycle = 1).
   task automatic scan_and_check(input string tag, input int ign_a, input int ign_b);
      int  c0, k;
      bit  seen;
      int  d0 = dones;
      int  f0 = busy_falls;
      push_scan();
      @(posedge clk); #2; start4 = 1'b1; c0 = cyc;
      @(posedge clk); #2; start4 = 1'b0;
      k    = 2;
      seen = 0;
      while (k < 210) begin
         @(negedge clk);
         if (done4 && !seen) begin
            seen = 1;
            check({tag, "_done_cycle"}, cyc - c0 + 1, 178);
         end
         @(posedge clk); #2;
         k++;
         start4 = (k == ign_a || k == ign_b);
      end
      start4 = 1'b0;
      @(negedge clk);
      if (!seen) check({tag, "_done_timeout"}, 0, 1);
      check({tag, "_done_count"}, dones - d0, 1);
      check({tag, "_busy_falls"}, busy_falls - f0, 1);
      check({tag, "_busy_end"}, busy4, 0);
      check({tag, "_sb_drained"}, sb_q.size(), 0);
   endtask

   initial begin
      int n, c0, d0;
      reset  = 1'b0;
      start4 = 1'b0; cont4 = 1'b0;
      start2 = 1'b0; cont2 = 1'b0;
      junk   = 8'h00;
      rtc_a4 = 8'h00;
      rtc_a2 = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 8'h00;
         bank2[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("init");
      @(posedge clk); #2; reset = 1'b1;
      repeat (2) @(posedge clk);

      // Basic scan with the RTC returning 0x50+index.
      for (int i = 0; i < 11; i++) mem[TB_TABLE[i]] = 8'h50 + 8'(i);
      scan_and_check("basic", 0, 0);

      // Start pulses while busy are ignored.
      randomize_mem();
      scan_and_check("ignore", 3, 100);

      // Reset during DATA of register 5 aborts the scan.
      randomize_mem();
      push_scan();
      @(posedge clk); #2; start4 = 1'b1;
      @(posedge clk); #2; start4 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(idx4 == 4'd5 && aod4) && n < 400);
      if (!(idx4 == 4'd5 && aod4)) check("abort_reach_data5", 0, 1);
      @(posedge clk); #2; reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("abort");
      sb_q.delete();
      @(posedge clk); #2; reset = 1'b1;
      repeat (2) @(posedge clk);

      // Full scan from index 0 after the abort.
      randomize_mem();
      scan_and_check("post_abort", 0, 0);

      // Continuous: start and continuous together, two back-to-back scans.
      randomize_mem();
      d0 = dones;
      push_scan();
      push_scan();
      @(posedge clk); #2; start4 = 1'b1; cont4 = 1'b1;
      @(posedge clk); #2; start4 = 1'b0;
      wait_done4(300, "cont1");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cs_n4 && n < 10);
      check("cont_gap", n, 2);
      repeat (40) @(posedge clk);
      #2; cont4 = 1'b0;
      wait_done4(300, "cont2");
      repeat (220) @(posedge clk);
      @(negedge clk);
      check("cont_done_count", dones - d0, 2);
      check("cont_busy_end", busy4, 0);
      check("cont_sb_drained", sb_q.size(), 0);

      // PHASE_CYC=2 instance feeding a register bank.
      randomize_mem();
      @(posedge clk); #2; start2 = 1'b1; c0 = cyc;
      @(posedge clk); #2; start2 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done2 && n < 300);
      if (!done2) check("p2_done_timeout", 0, 1);
      else check("p2_done_cycle", cyc - c0 + 1, 90);
      check("p2_busy_at_done", busy2, 0);
      check("p2_last_index", idx2, 10);
      check("p2_last_address", addr2, 8'h43);
      check("p2_cs_n_released", cs_n2, 1);
      for (int i = 0; i < 11; i++)
         check($sformatf("p2_bank_%0h", TB_TABLE[i]), bank2[TB_TABLE[i]], mem[TB_TABLE[i]]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
